// File: rtl/multicycle_datapath.sv
// multicycle_datapath: RV32I multicycle datapath with PC/IR/A/B/ALUOut/Data registers, regfile and unified memory port
module multicycle_datapath #(
  parameter logic [31:0] RESET_PC    = 32'h0000_0000,
  parameter logic [31:0] RESET_INSTR = 32'h0000_0013
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [1:0]  ImmSrc,
  input  logic [1:0]  ALUSrcA,
  input  logic [1:0]  ALUSrcB,
  input  logic [1:0]  ResultSrc,
  input  logic        AdrSrc,
  input  logic [2:0]  ALUControl,
  input  logic        IRWrite,
  input  logic        PCWrite,
  input  logic        RegWrite,
  input  logic [31:0] ReadData,
  output logic [6:0]  op,
  output logic [2:0]  funct3,
  output logic        funct7b5,
  output logic        Zero,
  output logic [31:0] Adr,
  output logic [31:0] WriteData,
  output logic [31:0] pc
);
  logic [31:0] old_pc, ir, data, a, b, alu_out;
  logic [31:0] rd1, rd2, imm_ext, src_a, src_b, alu_result, result;
  logic [31:0] rf [32];
  always_comb begin
    rd1 = ir[19:15] == 5'd0 ? '0 : rf[ir[19:15]];
    rd2 = ir[24:20] == 5'd0 ? '0 : rf[ir[24:20]];
    imm_ext = ImmSrc == 2'b00 ? {{20{ir[31]}}, ir[31:20]} :
              ImmSrc == 2'b01 ? {{20{ir[31]}}, ir[31:25], ir[11:7]} :
              ImmSrc == 2'b10 ? {{20{ir[31]}}, ir[7], ir[30:25], ir[11:8], 1'b0} :
                                {{12{ir[31]}}, ir[19:12], ir[20], ir[30:21], 1'b0};
    src_a = ALUSrcA == 2'b00 ? pc : ALUSrcA == 2'b01 ? old_pc : ALUSrcA == 2'b10 ? a : '0;
    src_b = ALUSrcB == 2'b00 ? b : ALUSrcB == 2'b01 ? imm_ext : ALUSrcB == 2'b10 ? 32'd4 : '0;
    alu_result = ALUControl == 3'b000 ? src_a + src_b :
                 ALUControl == 3'b001 ? src_a - src_b :
                 ALUControl == 3'b010 ? src_a & src_b :
                 ALUControl == 3'b011 ? src_a | src_b :
                 ALUControl == 3'b101 ? {31'd0, $signed(src_a) < $signed(src_b)} : '0;
    result = ResultSrc == 2'b00 ? alu_out : ResultSrc == 2'b01 ? data : ResultSrc == 2'b10 ? alu_result : '0;
  end
  assign Zero      = alu_result == '0;
  assign Adr       = AdrSrc ? result : pc;
  assign WriteData = b;
  assign op        = ir[6:0];
  assign funct3    = ir[14:12];
  assign funct7b5  = ir[30];
  always_ff @(posedge clk) begin
    if (!reset) begin
      pc      <= RESET_PC;
      ir      <= RESET_INSTR;
      old_pc  <= '0;
      data    <= '0;
      a       <= '0;
      b       <= '0;
      alu_out <= '0;
    end else begin
      data    <= ReadData;
      a       <= rd1;
      b       <= rd2;
      alu_out <= alu_result;
      if (IRWrite) begin
        ir     <= ReadData;
        old_pc <= pc;
      end
      if (PCWrite) pc <= result;
    end
  end
  always_ff @(posedge clk)
    if (reset && RegWrite && ir[11:7] != 5'd0) rf[ir[11:7]] <= result;
endmodule

// File: tb/tb_multicycle_datapath.sv
// tb_multicycle_datapath: scoreboard bench driving hand-sequenced multicycle control words
module tb_multicycle_datapath;
  logic        clk = 1'b0;
  logic        reset;
  logic [1:0]  ImmSrc, ALUSrcA, ALUSrcB, ResultSrc;
  logic        AdrSrc, IRWrite, PCWrite, RegWrite;
  logic [2:0]  ALUControl;
  logic [31:0] ReadData;
  logic [6:0]  op;
  logic [2:0]  funct3;
  logic        funct7b5, Zero;
  logic [31:0] Adr, WriteData, pc;

  localparam int S_PC = 0, S_OP = 1, S_F3 = 2, S_ZERO = 3, S_ADR = 4, S_WD = 5, S_F7 = 6;

  typedef struct {
    string       name;
    int          sel;
    logic [31:0] exp;
  } chk_t;

  chk_t        q[$];
  int          total = 0;
  int          bad = 0;
  logic [31:0] mpc;

  multicycle_datapath dut (
    .clk(clk), .reset(reset), .ImmSrc(ImmSrc), .ALUSrcA(ALUSrcA), .ALUSrcB(ALUSrcB),
    .ResultSrc(ResultSrc), .AdrSrc(AdrSrc), .ALUControl(ALUControl), .IRWrite(IRWrite),
    .PCWrite(PCWrite), .RegWrite(RegWrite), .ReadData(ReadData), .op(op), .funct3(funct3),
    .funct7b5(funct7b5), .Zero(Zero), .Adr(Adr), .WriteData(WriteData), .pc(pc)
  );

  always #5 clk = ~clk;

  function automatic logic [31:0] obs(int sel);
    case (sel)
      S_PC:    return pc;
      S_OP:    return {25'd0, op};
      S_F3:    return {29'd0, funct3};
      S_ZERO:  return {31'd0, Zero};
      S_ADR:   return Adr;
      S_WD:    return WriteData;
      default: return {31'd0, funct7b5};
    endcase
  endfunction

  always @(negedge clk) begin
    chk_t        c;
    logic [31:0] got;
    while (q.size() > 0) begin
      c = q.pop_front();
      got = obs(c.sel);
      total++;
      if (got !== c.exp) begin
        bad++;
        $display("FAIL %s: got %h expected %h at %0t", c.name, got, c.exp, $time);
      end
    end
  end

  task automatic chk(input string n, input int s, input logic [31:0] v);
    q.push_back('{n, s, v});
  endtask

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic ctl(input logic [1:0] imm, sa, sb, rs, input logic ad, input logic [2:0] alu,
                     input logic irw, pcw, rw);
    ImmSrc = imm; ALUSrcA = sa; ALUSrcB = sb; ResultSrc = rs; AdrSrc = ad;
    ALUControl = alu; IRWrite = irw; PCWrite = pcw; RegWrite = rw;
  endtask

  task automatic fetch(input logic [31:0] instr);
    ReadData = instr;
    ctl(2'b00, 2'b00, 2'b10, 2'b10, 1'b0, 3'b000, 1'b1, 1'b1, 1'b0);
    chk("fetch_adr", S_ADR, mpc);
    cyc();
    mpc = mpc + 32'd4;
  endtask

  task automatic decode(input logic [6:0] eop);
    ctl(2'b00, 2'b01, 2'b11, 2'b10, 1'b1, 3'b000, 1'b0, 1'b0, 1'b0);
    chk("dec_pc", S_PC, mpc);
    chk("dec_op", S_OP, {25'd0, eop});
    chk("dec_oldpc", S_ADR, mpc - 32'd4);
    cyc();
  endtask

  task automatic exec(input logic [1:0] imm, sa, sb, input logic [2:0] alu, input logic [31:0] e);
    ctl(imm, sa, sb, 2'b10, 1'b1, alu, 1'b0, 1'b0, 1'b0);
    chk("exec_result", S_ADR, e);
    chk("exec_zero", S_ZERO, {31'd0, e == 32'd0});
    cyc();
  endtask

  task automatic wb(input logic [1:0] rs, input logic rw, input logic [31:0] e);
    ctl(2'b00, 2'b00, 2'b00, rs, 1'b1, 3'b000, 1'b0, 1'b0, rw);
    chk("wb_result", S_ADR, e);
    cyc();
  endtask

  initial begin
    reset = 1'b0;
    ReadData = '0;
    mpc = '0;
    ctl(2'b00, 2'b00, 2'b00, 2'b00, 1'b0, 3'b000, 1'b0, 1'b0, 1'b0);
    cyc();
    cyc();
    chk("rst_pc", S_PC, 32'd0);
    chk("rst_op", S_OP, 32'h13);
    chk("rst_f3", S_F3, 32'd0);
    chk("rst_adr", S_ADR, 32'd0);
    reset = 1'b1;
    cyc();
    chk("hold_pc", S_PC, 32'd0);
    cyc();
    chk("hold_pc2", S_PC, 32'd0);
    // addi x1,x0,4 and addi x2,x0,4
    fetch(32'h0040_0093);
    decode(7'h13);
    exec(2'b00, 2'b10, 2'b01, 3'b000, 32'd4);
    wb(2'b00, 1'b1, 32'd4);
    fetch(32'h0040_0113);
    decode(7'h13);
    exec(2'b00, 2'b10, 2'b01, 3'b000, 32'd4);
    wb(2'b00, 1'b1, 32'd4);
    // sub x3,x1,x2 then ALU op sweep on the same operands
    fetch(32'h4020_81B3);
    chk("sub_f7b5", S_F7, 32'd1);
    decode(7'h33);
    chk("sub_wd", S_WD, 32'd4);
    exec(2'b00, 2'b10, 2'b00, 3'b001, 32'd0);
    exec(2'b00, 2'b10, 2'b00, 3'b000, 32'd8);
    wb(2'b00, 1'b0, 32'd8);
    exec(2'b00, 2'b10, 2'b00, 3'b010, 32'd4);
    exec(2'b00, 2'b10, 2'b00, 3'b011, 32'd4);
    exec(2'b00, 2'b10, 2'b00, 3'b111, 32'd0);
    // write to x0 must be dropped
    fetch(32'h0000_0013);
    ReadData = 32'hDEAD_BEEF;
    decode(7'h13);
    ReadData = '0;
    wb(2'b01, 1'b1, 32'hDEAD_BEEF);
    ctl(2'b00, 2'b00, 2'b00, 2'b00, 1'b0, 3'b000, 1'b0, 1'b0, 1'b0);
    cyc();
    exec(2'b00, 2'b10, 2'b11, 3'b000, 32'd0);
    // lw x5,0x100(x0)
    fetch(32'h1000_2283);
    chk("lw_f3", S_F3, 32'd2);
    decode(7'h03);
    exec(2'b00, 2'b10, 2'b01, 3'b000, 32'h100);
    ReadData = 32'h1234_5678;
    wb(2'b00, 1'b0, 32'h100);
    ReadData = '0;
    wb(2'b01, 1'b1, 32'h1234_5678);
    fetch(32'h0002_8033);
    decode(7'h33);
    exec(2'b00, 2'b10, 2'b11, 3'b000, 32'h1234_5678);
    // addi x6,x0,-1 ; slt x7,x6,x1
    fetch(32'hFFF0_0313);
    decode(7'h13);
    exec(2'b00, 2'b10, 2'b01, 3'b000, 32'hFFFF_FFFF);
    wb(2'b00, 1'b1, 32'hFFFF_FFFF);
    fetch(32'h0013_23B3);
    decode(7'h33);
    chk("slt_wd", S_WD, 32'd4);
    exec(2'b00, 2'b10, 2'b00, 3'b101, 32'd1);
    // immediate formats decoded from IR = 0x001323B3
    exec(2'b01, 2'b11, 2'b01, 3'b000, 32'h0000_0007);
    exec(2'b10, 2'b11, 2'b01, 3'b000, 32'h0000_0806);
    exec(2'b11, 2'b11, 2'b01, 3'b000, 32'h0003_2800);
    // reset during a fetch overrides IRWrite/PCWrite
    ReadData = 32'h0040_0093;
    ctl(2'b00, 2'b00, 2'b10, 2'b10, 1'b0, 3'b000, 1'b1, 1'b1, 1'b0);
    reset = 1'b0;
    cyc();
    reset = 1'b1;
    ctl(2'b00, 2'b00, 2'b00, 2'b00, 1'b0, 3'b000, 1'b0, 1'b0, 1'b0);
    mpc = '0;
    chk("mid_rst_pc", S_PC, 32'd0);
    chk("mid_rst_op", S_OP, 32'h13);
    chk("mid_rst_f3", S_F3, 32'd0);
    chk("mid_rst_wd", S_WD, 32'd0);
    cyc();
    fetch(32'h0040_0093);
    decode(7'h13);
    @(negedge clk);
    #1;
    if (q.size() != 0) begin
      bad++;
      $display("FAIL scoreboard_drain: got %0d pending expected 0", q.size());
    end
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
